// File: rtl/uart_pkg.sv
// Shared UART constants and arbiter state encoding.
package uart_pkg;

   localparam int CLK_HZ                 = 50_000_000;
   localparam int BAUD_RATE              = 115_200;
   localparam int CLKS_PER_BIT           = CLK_HZ / BAUD_RATE;
   // Roughly one 12-bit frame time: long enough that a healthy requester
   // never trips it between bytes of a packet.
   localparam int TIMEOUT_CYCLES_DEFAULT = CLK_HZ / BAUD_RATE * 12;

   typedef enum logic {
      ARB  = 1'b0,
      SEND = 1'b1
   } arb_state_e;

   // Round-robin index helper: (base + offset) mod n.
   function automatic int rr_wrap(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req starting just
// after last_grant, wrapping around.
module rr_picker
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_grant,
   output logic [$clog2(N_REQ)-1:0] grant,
   output logic                     any
);

   localparam int IDX_W = $clog2(N_REQ);

   // Walk the N_REQ candidates in priority order; the first hit wins.
   always_comb begin
      logic [IDX_W-1:0] idx;
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = IDX_W'(rr_wrap(int'(last_grant), i, N_REQ));
         if (!any && req[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a single UART transmitter.
// A granted requester owns the transmitter until it sends a byte flagged
// last, or until it leaves its valid low for TIMEOUT_CYCLES consecutive
// cycles while owning the lock.
//
//   state | meaning
//   ARB   | no owner; pick next requester, all outputs quiet
//   SEND  | grant_id owns the transmitter; bytes pass straight through
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int BITS_N         = 8,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ*BITS_N-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic [BITS_N-1:0]         data_tx,
   output logic                      valid,
   input  logic                      tx_ready,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [WD_W-1:0]  WD_TERMINAL    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(N_REQ - 1);

   arb_state_e        state, state_nxt;
   logic [IDX_W-1:0]  grant_q, grant_nxt;
   logic [IDX_W-1:0]  last_q, last_nxt;
   logic [WD_W-1:0]   wd_q, wd_nxt;

   logic [IDX_W-1:0]  pick;
   logic              pick_any;

   logic              sel_valid;
   logic              sel_last;
   logic [BITS_N-1:0] sel_data;
   logic              xfer;

   logic              valid_c;
   logic [BITS_N-1:0] data_c;
   logic [N_REQ-1:0]  ready_c;
   logic              tmo_c;

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_rr_picker (
      .req        (req_valid),
      .last_grant (last_q),
      .grant      (pick),
      .any        (pick_any)
   );

   assign sel_valid = req_valid[grant_q];
   assign sel_last  = req_last[grant_q];
   assign sel_data  = req_data[int'(grant_q)*BITS_N +: BITS_N];
   assign xfer      = (state == SEND) && sel_valid && tx_ready;

   // State, owner, round-robin pointer and watchdog registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ARB;
         grant_q <= '0;
         last_q  <= LAST_GRANT_RST;
         wd_q    <= '0;
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         last_q  <= last_nxt;
         wd_q    <= wd_nxt;
      end
   end

   // Next-state, watchdog and pass-through output decode.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      last_nxt  = last_q;
      wd_nxt    = wd_q;
      valid_c   = 1'b0;
      data_c    = '0;
      ready_c   = '0;
      tmo_c     = 1'b0;

      case (state)
         ARB: begin
            wd_nxt = '0;
            if (pick_any) begin
               grant_nxt = pick;
               state_nxt = SEND;
            end
         end

         SEND: begin
            valid_c          = sel_valid;
            data_c           = sel_data;
            ready_c[grant_q] = tx_ready;

            // Watchdog only runs while the owner has nothing to offer;
            // a stalled transmitter with valid high never trips it.
            if (sel_valid) begin
               wd_nxt = '0;
            end else if (wd_q == WD_TERMINAL) begin
               tmo_c     = 1'b1;
               wd_nxt    = '0;
               last_nxt  = grant_q;
               state_nxt = ARB;
            end else begin
               wd_nxt = wd_q + 1'b1;
            end

            if (xfer && sel_last) begin
               last_nxt  = grant_q;
               state_nxt = ARB;
            end
         end

         default: begin
            state_nxt = ARB;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held so an abandoned packet
   // never shows a byte during the reset cycle itself.
   assign valid       = valid_c & ~reset;
   assign data_tx     = reset ? '0 : data_c;
   assign req_ready   = reset ? '0 : ready_c;
   assign timeout_err = tmo_c & ~reset;
   assign busy        = (state == SEND) & ~reset;
   assign grant_id    = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter BITS_N, default 8, bits per UART byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000/115_200*12, idle-lock watchdog limit.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_data  input  N_REQ*BITS_N  byte per requester; requester i uses bits [i*BITS_N +: BITS_N].
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester byte valid.
REQ-008 SHALL have port req_last  input  N_REQ  marks the final byte of a packet.
REQ-009 SHALL have port req_ready  output  N_REQ  per-requester byte accepted.
REQ-010 SHALL have port data_tx  output  BITS_N  byte to the UART transmitter.
REQ-011 SHALL have port valid  output  1  byte valid to the UART transmitter.
REQ-012 SHALL have port tx_ready  input  1  UART transmitter idle and accepting.
REQ-013 SHALL have port grant_id  output  $clog2(N_REQ)  current owner.
REQ-014 SHALL have port busy  output  1  high outside ARB.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog release.

Function
REQ-016 SHALL implement FSM states ARB, SEND.
REQ-017 SHALL, in ARB with any req_valid high, grant the first valid requester searching from (last_grant+1) mod N_REQ upward with wrap-around, register grant_id, and enter SEND next cycle.
REQ-018 SHALL stay in ARB while req_valid is all-zero.
REQ-019 SHALL, in SEND, drive valid=req_valid[grant_id], data_tx=req_data[grant_id], req_ready[grant_id]=tx_ready; all other req_ready bits 0.
REQ-020 SHALL count a byte transferred when valid and tx_ready are both high in the same cycle.
REQ-021 SHALL, on a transfer with req_last[grant_id]=1, set last_grant=grant_id and return to ARB next cycle.
REQ-022 SHALL, on a transfer with req_last[grant_id]=0, stay in SEND, locked to grant_id.
REQ-023 SHALL drive valid=0, req_ready=0 and data_tx=0 in ARB; zero added latency beyond the one ARB cycle per packet.
REQ-024 SHALL count cycles in SEND where req_valid[grant_id]=0 and reset the count on any cycle it is 1.
REQ-025 SHALL, when that count reaches TIMEOUT_CYCLES, pulse timeout_err for one cycle, set last_grant=grant_id and enter ARB.
REQ-026 SHALL never present more than one requester's byte; a requester dropping req_valid mid-packet keeps the lock until last or timeout.
REQ-027 SHALL tolerate tx_ready low in SEND indefinitely (no watchdog while req_valid is high).

Reset
REQ-028 SHALL on reset enter ARB, set last_grant=N_REQ-1 (so requester 0 wins first), grant_id=0, watchdog count 0.
REQ-029 SHALL hold valid=0, req_ready=0, busy=0, timeout_err=0 during and the cycle after reset, including reset mid-packet (packet abandoned, no byte re-sent).

Structure
REQ-030 SHALL place the state enum and default TIMEOUT/CLKS_PER_BIT constants in shared package uart_pkg.
REQ-031 SHALL use one sub-module rr_picker (combinational round-robin search: req mask, last_grant -> grant index, any).
REQ-032 SHALL connect directly to the existing UART transmitter's data_tx/valid/tx_ready ports without glue.

Verification
REQ-033 Reset, then req_valid=4'b0001, data 0x41, last=1 -> grant_id=0, one transfer of 0x41, return to ARB.
REQ-034 All four requesters valid, single-byte packets -> grant order 0,1,2,3,0.
REQ-035 Requester 2 sends 3-byte packet 0x10,0x11,0x12 (last on 0x12) while 1 and 3 valid -> bytes contiguous, no interleaving, then requester 3 granted.
REQ-036 Requester 1 drops valid after first non-last byte -> timeout_err pulses after exactly TIMEOUT_CYCLES cycles, next valid requester granted.
REQ-037 Assert reset while tx_ready=0 mid-packet -> valid=0 next cycle, FSM in ARB, requester 0 wins next arbitration.
REQ-038 Hold tx_ready=0 for 1000 cycles with valid high -> no transfer, no timeout_err, data_tx stable.
